// File: rtl/record_serializer.sv
// record_serializer: pops capture records, drops them by type nibble, and frames survivors as a
// header byte plus DW/8 payload bytes (plus CRC-8 when RECORD_SERIALIZER_CRC_EN is defined).
module record_serializer #(
    parameter int unsigned DW          = 48,
    parameter bit          MSB_FIRST   = 1'b1,
    parameter logic [15:0] FILTER_MASK = 16'hFFFF
) (
    input  logic          clock,
    input  logic          reset,
    input  logic          read_empty,
    input  logic [DW-1:0] read_data,
    output logic          read_clock_enable,
    input  logic          overflow,
    input  logic          uart_ready,
    output logic [7:0]    uart_data,
    output logic          uart_clock_enable,
    output logic [15:0]   dropped_count
);

    localparam int unsigned   NB       = DW / 8;
    localparam int unsigned   IW       = $clog2(NB);
    localparam logic [IW-1:0] LAST_IDX = IW'(NB - 1);

    localparam logic [7:0] HDR_OVF   = 8'hA5;
    localparam logic [7:0] HDR_CLEAN = 8'h5A;

    typedef enum logic [2:0] {
        StIdle,
        StFilter,
        StHeader,
        StData,
`ifdef RECORD_SERIALIZER_CRC_EN
        StCrc,
`endif
        StGuard
    } state_e;

    state_e        state_q, state_d;
    state_e        ret_q, ret_d;
    logic [DW-1:0] rec_q, rec_d;
    logic [IW-1:0] idx_q, idx_d;
    logic          ovf_q, ovf_d;
    logic [15:0]   drop_q, drop_d;
    logic [7:0]    data_q, data_d;

    logic          pop;
    logic          strobe;
    logic          hdr_strobe;
    logic [7:0]    tx_byte;
    logic [IW-1:0] sel;
    logic [7:0]    payload_byte;

    assign sel          = MSB_FIRST ? (LAST_IDX - idx_q) : idx_q;
    assign payload_byte = rec_q[{sel, 3'b000} +: 8];

`ifdef RECORD_SERIALIZER_CRC_EN
    logic [7:0] crc_q, crc_d;

    function automatic logic [7:0] crc8_byte(input logic [7:0] crc, input logic [7:0] b);
        logic [7:0] c;
        c = crc ^ b;
        for (int i = 0; i < 8; i++) begin
            c = c[7] ? ((c << 1) ^ 8'h07) : (c << 1);
        end
        return c;
    endfunction
`endif

    always_comb begin
        state_d    = state_q;
        ret_d      = ret_q;
        rec_d      = rec_q;
        idx_d      = idx_q;
        drop_d     = drop_q;
        pop        = 1'b0;
        strobe     = 1'b0;
        hdr_strobe = 1'b0;
        tx_byte    = data_q;

        case (state_q)
            StIdle: begin
                if (!read_empty) begin
                    pop     = 1'b1;
                    rec_d   = read_data;
                    state_d = StFilter;
                end
            end
            StFilter: begin
                if (FILTER_MASK[rec_q[3:0]]) begin
                    state_d = StHeader;
                end else begin
                    if (drop_q != 16'hFFFF) begin
                        drop_d = drop_q + 16'd1;
                    end
                    state_d = StIdle;
                end
            end
            StHeader: begin
                if (uart_ready) begin
                    strobe     = 1'b1;
                    hdr_strobe = 1'b1;
                    tx_byte    = ovf_q ? HDR_OVF : HDR_CLEAN;
                    idx_d      = '0;
                    ret_d      = StData;
                    state_d    = StGuard;
                end
            end
            StData: begin
                if (uart_ready) begin
                    strobe  = 1'b1;
                    tx_byte = payload_byte;
                    idx_d   = idx_q + 1'b1;
                    if (idx_q == LAST_IDX) begin
`ifdef RECORD_SERIALIZER_CRC_EN
                        ret_d = StCrc;
`else
                        ret_d = StIdle;
`endif
                    end else begin
                        ret_d = StData;
                    end
                    state_d = StGuard;
                end
            end
`ifdef RECORD_SERIALIZER_CRC_EN
            StCrc: begin
                if (uart_ready) begin
                    strobe  = 1'b1;
                    tx_byte = crc_q;
                    ret_d   = StIdle;
                    state_d = StGuard;
                end
            end
`endif
            // Transmitter drops ready only the cycle after a strobe, so ready is not trusted here.
            StGuard: state_d = ret_q;
            default: state_d = StIdle;
        endcase
    end

    // A set in the same cycle as the header clear wins.
    assign ovf_d  = overflow | (ovf_q & ~hdr_strobe);
    assign data_d = uart_clock_enable ? tx_byte : data_q;

`ifdef RECORD_SERIALIZER_CRC_EN
    always_comb begin
        crc_d = crc_q;
        if (state_q == StFilter) begin
            crc_d = 8'h00;
        end else if (strobe && (state_q != StCrc)) begin
            crc_d = crc8_byte(crc_q, tx_byte);
        end
    end
`endif

    // Strobes are suppressed while reset is held so nothing is popped or sent during reset.
    assign read_clock_enable = pop & ~reset;
    assign uart_clock_enable = strobe & ~reset;
    assign uart_data         = uart_clock_enable ? tx_byte : data_q;
    assign dropped_count     = drop_q;

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= StIdle;
            ret_q   <= StIdle;
            rec_q   <= '0;
            idx_q   <= '0;
            ovf_q   <= 1'b0;
            drop_q  <= '0;
            data_q  <= '0;
`ifdef RECORD_SERIALIZER_CRC_EN
            crc_q   <= '0;
`endif
        end else begin
            state_q <= state_d;
            ret_q   <= ret_d;
            rec_q   <= rec_d;
            idx_q   <= idx_d;
            ovf_q   <= ovf_d;
            drop_q  <= drop_d;
            data_q  <= data_d;
`ifdef RECORD_SERIALIZER_CRC_EN
            crc_q   <= crc_d;
`endif
        end
    end

    a_strobe_spacing: assert property (@(posedge clock) disable iff (reset)
        uart_clock_enable |=> !uart_clock_enable);
    a_pop_only_idle: assert property (@(posedge clock) disable iff (reset)
        read_clock_enable |-> (state_q == StIdle));

endmodule

// File: tb/tb_record_serializer.sv
// Directed bench for record_serializer: framing, byte order, filtering, overflow header, stall and
// mid-record reset. A CRC byte is expected per record when RECORD_SERIALIZER_CRC_EN is defined.
`timescale 1ns/1ps
module tb_record_serializer;

`ifdef RECORD_SERIALIZER_CRC_EN
    localparam int CRC_B = 1;
`else
    localparam int CRC_B = 0;
`endif
    localparam int NI = 4;
    localparam int REC48 = 7 + CRC_B;

    logic clock = 1'b0;
    logic reset;
    always #5 clock = ~clock;

    logic        rd_empty [NI];
    logic [47:0] rd_data  [NI];
    logic        rce      [NI];
    logic        ovf      [NI];
    logic        rdy      [NI];
    logic [7:0]  ud       [NI];
    logic        uce      [NI];
    logic [15:0] dcnt     [NI];

    // Ring-buffer model per instance
    logic [47:0] mem  [NI][16];
    logic [3:0]  head [NI] = '{4'd0, 4'd0, 4'd0, 4'd0};
    logic [3:0]  tail [NI] = '{4'd0, 4'd0, 4'd0, 4'd0};

    for (genvar g = 0; g < NI; g++) begin : g_rb
        assign rd_empty[g] = (head[g] == tail[g]);
        assign rd_data[g]  = mem[g][head[g]];
    end

    always @(posedge clock) begin
        for (int i = 0; i < NI; i++) begin
            if (rce[i] === 1'b1) head[i] <= head[i] + 4'd1;
        end
    end

    record_serializer #(.DW(48), .MSB_FIRST(1'b1), .FILTER_MASK(16'hFFFF)) u_msb (
        .clock(clock), .reset(reset), .read_empty(rd_empty[0]), .read_data(rd_data[0]),
        .read_clock_enable(rce[0]), .overflow(ovf[0]), .uart_ready(rdy[0]), .uart_data(ud[0]),
        .uart_clock_enable(uce[0]), .dropped_count(dcnt[0]));

    record_serializer #(.DW(48), .MSB_FIRST(1'b0), .FILTER_MASK(16'hFFFF)) u_lsb (
        .clock(clock), .reset(reset), .read_empty(rd_empty[1]), .read_data(rd_data[1]),
        .read_clock_enable(rce[1]), .overflow(ovf[1]), .uart_ready(rdy[1]), .uart_data(ud[1]),
        .uart_clock_enable(uce[1]), .dropped_count(dcnt[1]));

    record_serializer #(.DW(48), .MSB_FIRST(1'b1), .FILTER_MASK(16'hFFFB)) u_flt (
        .clock(clock), .reset(reset), .read_empty(rd_empty[2]), .read_data(rd_data[2]),
        .read_clock_enable(rce[2]), .overflow(ovf[2]), .uart_ready(rdy[2]), .uart_data(ud[2]),
        .uart_clock_enable(uce[2]), .dropped_count(dcnt[2]));

    record_serializer #(.DW(16), .MSB_FIRST(1'b1), .FILTER_MASK(16'hFFFF)) u_d16 (
        .clock(clock), .reset(reset), .read_empty(rd_empty[3]), .read_data(rd_data[3][15:0]),
        .read_clock_enable(rce[3]), .overflow(ovf[3]), .uart_ready(rdy[3]), .uart_data(ud[3]),
        .uart_clock_enable(uce[3]), .dropped_count(dcnt[3]));

    // Strobe / pop monitor, sampled mid-cycle
    int         cycnt = 0;
    logic [7:0] bytes [NI][48];
    int         bcyc  [NI][48];
    int         nb    [NI] = '{0, 0, 0, 0};
    int         pops  [NI] = '{0, 0, 0, 0};
    int         pcyc  [NI][8];

    always @(posedge clock) cycnt <= cycnt + 1;

    always @(negedge clock) begin
        for (int i = 0; i < NI; i++) begin
            if (uce[i] === 1'b1 && nb[i] < 48) begin
                bytes[i][nb[i]] <= ud[i];
                bcyc[i][nb[i]]  <= cycnt;
                nb[i]           <= nb[i] + 1;
            end
            if (rce[i] === 1'b1 && pops[i] < 8) begin
                pcyc[i][pops[i]] <= cycnt;
                pops[i]          <= pops[i] + 1;
            end
        end
    end

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clock);
        #1;
    endtask

    task automatic push(input int i, input logic [47:0] r);
        mem[i][tail[i]] = r;
        tail[i] = tail[i] + 4'd1;
    endtask

    task automatic wait_nb(input int i, input int target, input int budget, input string tag);
        for (int k = 0; k < budget && nb[i] < target; k++) step(1);
        check_eq(tag, nb[i], target);
    endtask

    logic [7:0] exp_b [16];

    // Expected bytes packed first-byte-leftmost in the low n bytes of v
    task automatic set_exp(input logic [127:0] v, input int n);
        for (int k = 0; k < n; k++) exp_b[k] = v[8*(n-1-k) +: 8];
    endtask

`ifdef RECORD_SERIALIZER_CRC_EN
    function automatic logic [7:0] crc8(input int n);
        logic [7:0] c;
        c = 8'h00;
        for (int k = 0; k < n; k++) begin
            c = c ^ exp_b[k];
            for (int b = 0; b < 8; b++) c = c[7] ? ((c << 1) ^ 8'h07) : (c << 1);
        end
        return c;
    endfunction
`endif

    task automatic check_stream(input int i, input int base, input int n, input bit spaced,
                                input string tag);
        for (int k = 0; k < n; k++) begin
            check_eq($sformatf("%s_byte%0d", tag, k), bytes[i][base+k], exp_b[k]);
        end
`ifdef RECORD_SERIALIZER_CRC_EN
        check_eq($sformatf("%s_crc", tag), bytes[i][base+n], crc8(n));
`endif
        if (spaced) begin
            for (int k = 1; k < n + CRC_B; k++) begin
                check_eq($sformatf("%s_gap%0d", tag, k),
                         bcyc[i][base+k] - bcyc[i][base+k-1], 2);
            end
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int base;
        int n0;
        int rel;
        int p;

        reset = 1'b1;
        for (int i = 0; i < NI; i++) begin
            rdy[i] = 1'b0;
            ovf[i] = 1'b0;
        end
        step(3);
        reset = 1'b0;
        step(1);
        for (int i = 0; i < NI; i++) begin
            check_eq($sformatf("rst_rce%0d", i), rce[i], 0);
            check_eq($sformatf("rst_uce%0d", i), uce[i], 0);
            check_eq($sformatf("rst_ud%0d", i), ud[i], 0);
            check_eq($sformatf("rst_dcnt%0d", i), dcnt[i], 0);
        end

        // MSB-first record
        rdy[0] = 1'b1;
        push(0, 48'h123456789A02);
        wait_nb(0, REC48, 60, "t1_len");
        step(10);
        check_eq("t1_no_extra", nb[0], REC48);
        check_eq("t1_pops", pops[0], 1);
        check_eq("t1_latency", bcyc[0][0] - pcyc[0][0], 2);
        set_exp({8'h5A, 48'h123456789A02}, 7);
        check_stream(0, 0, 7, 1'b1, "t1");

        // LSB-first record
        rdy[1] = 1'b1;
        push(1, 48'h123456789A02);
        wait_nb(1, REC48, 60, "t2_len");
        check_eq("t2_pops", pops[1], 1);
        set_exp({8'h5A, 48'h029A78563412}, 7);
        check_stream(1, 0, 7, 1'b1, "t2");

        // Filtering: type 2 dropped, type 3 sent
        rdy[2] = 1'b1;
        push(2, 48'h111111111102);
        push(2, 48'hAABBCCDDEE03);
        wait_nb(2, REC48, 60, "t3_len");
        step(10);
        check_eq("t3_no_extra", nb[2], REC48);
        check_eq("t3_dropped", dcnt[2], 1);
        check_eq("t3_pops", pops[2], 2);
        check_eq("t3_pop_gap", pcyc[2][1] - pcyc[2][0], 2);
        check_eq("t3_latency", bcyc[2][0] - pcyc[2][1], 2);
        set_exp({8'h5A, 48'hAABBCCDDEE03}, 7);
        check_stream(2, 0, 7, 1'b1, "t3");

        // Overflow while idle flags only the next header
        base = nb[0];
        ovf[0] = 1'b1;
        step(1);
        ovf[0] = 1'b0;
        step(2);
        push(0, 48'h000000000001);
        push(0, 48'h000000000004);
        wait_nb(0, base + 2 * REC48, 120, "t4_len");
        set_exp({8'hA5, 48'h000000000001}, 7);
        check_stream(0, base, 7, 1'b0, "t4a");
        set_exp({8'h5A, 48'h000000000004}, 7);
        check_stream(0, base + REC48, 7, 1'b0, "t4b");

        // Back-pressure after the third byte
        base = nb[0];
        push(0, 48'hC0C1C2C3C4C5);
        wait_nb(0, base + 3, 40, "t5_pre");
        rdy[0] = 1'b0;
        n0 = nb[0];
        step(50);
        check_eq("t5_hold", nb[0], n0);
        rdy[0] = 1'b1;
        rel = cycnt;
        wait_nb(0, base + REC48, 40, "t5_len");
        check_eq("t5_resume", (bcyc[0][base+3] - rel) <= 1, 1);
        set_exp({8'h5A, 48'hC0C1C2C3C4C5}, 7);
        check_stream(0, base, 7, 1'b0, "t5");

        // 16-bit record, then reset in the middle of the next one
        rdy[3] = 1'b1;
        push(3, 48'h000000000000);
        wait_nb(3, 3 + CRC_B, 40, "t6_len");
        set_exp({8'h5A, 16'h0000}, 3);
        check_stream(3, 0, 3, 1'b1, "t6");
`ifdef RECORD_SERIALIZER_CRC_EN
        check_eq("t6_crc_a3", bytes[3][3], 8'hA3);
`endif
        base = nb[3];
        p = pops[3];
        push(3, 48'h000000001234);
        wait_nb(3, base + 2, 40, "t7_pre");
        reset = 1'b1;
        step(2);
        reset = 1'b0;
        step(20);
        check_eq("t7_byte1", bytes[3][base+1], 8'h12);
        check_eq("t7_no_more", nb[3], base + 2);
        check_eq("t7_pops", pops[3], p + 1);
        check_eq("t7_rce", rce[3], 0);
        check_eq("t7_uce", uce[3], 0);
        check_eq("t7_ud", ud[3], 0);
        check_eq("t7_dcnt_flt", dcnt[2], 0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
